// File: rtl/button_event_ctrl.sv
// Per-button press/release/long/repeat event scheduler with round-robin arbitration into an event FIFO.
// Optional feature macro: AUTO_REPEAT_EN enables periodic REPEAT events while a button is held long.
module button_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         btn_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic [1:0]                 evt_type,
  output logic                       tick,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int BW   = $clog2(NUM_BTN);
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(MAXT + 1);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} state_t;

  logic [TW-1:0]              tick_cnt;
  logic [NUM_BTN-1:0]         btn_q, btn_qq, rise, fall;
  state_t                     state    [NUM_BTN];
  logic [HW-1:0]              hold_cnt [NUM_BTN];
  logic [NUM_BTN-1:0]         raise;
  logic [NUM_BTN-1:0][1:0]    raise_type;
  logic [NUM_BTN-1:0]         pend_valid;
  logic [NUM_BTN-1:0][1:0]    pend_type;
  logic [NUM_BTN-1:0]         gnt, drop;
  logic                       gnt_any;
  logic [BW-1:0]              gnt_idx, rr_ptr, scan_idx;
  logic [BW+1:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       fifo_full, push, pop;

  // Free-running timebase; tick is high while the counter sits at 0 after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (tick_cnt == TW'(TICK_DIV - 1));
      if (tick_cnt == TW'(TICK_DIV - 1)) tick_cnt <= '0;
      else                               tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      btn_qq <= '0;
    end else begin
      btn_q  <= btn_in;
      btn_qq <= btn_q;
    end
  end

  assign rise = btn_q & ~btn_qq;
  assign fall = ~btn_q & btn_qq;

  always_comb begin
    raise      = '0;
    raise_type = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      case (state[i])
        S_IDLE:
          if (rise[i]) begin raise[i] = 1'b1; raise_type[i] = EV_PRESS; end
        S_PRESSED:
          if (fall[i]) begin raise[i] = 1'b1; raise_type[i] = EV_RELEASE; end
          else if (hold_cnt[i] == HW'(LONG_TICKS)) begin raise[i] = 1'b1; raise_type[i] = EV_LONG; end
        S_LONG:
          if (fall[i]) begin raise[i] = 1'b1; raise_type[i] = EV_RELEASE; end
`ifdef AUTO_REPEAT_EN
          else if (hold_cnt[i] == HW'(REPEAT_TICKS)) begin raise[i] = 1'b1; raise_type[i] = EV_REPEAT; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i]    <= S_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          S_IDLE:
            if (rise[i]) begin state[i] <= S_PRESSED; hold_cnt[i] <= '0; end
          S_PRESSED:
            if (fall[i]) state[i] <= S_IDLE;
            else if (hold_cnt[i] == HW'(LONG_TICKS)) begin state[i] <= S_LONG; hold_cnt[i] <= '0; end
            else if (tick) hold_cnt[i] <= hold_cnt[i] + 1'b1;
          S_LONG:
            if (fall[i]) state[i] <= S_IDLE;
`ifdef AUTO_REPEAT_EN
            else if (hold_cnt[i] == HW'(REPEAT_TICKS)) hold_cnt[i] <= '0;
            else if (tick) hold_cnt[i] <= hold_cnt[i] + 1'b1;
`endif
          default: state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Round-robin scan starting at rr_ptr; nothing is granted while the FIFO is full.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt      = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      scan_idx = ((int'(rr_ptr) + k) >= NUM_BTN) ? BW'(int'(rr_ptr) + k - NUM_BTN)
                                                 : BW'(int'(rr_ptr) + k);
      if (!gnt_any && !fifo_full && pend_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign drop = raise & pend_valid & ~gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      pend_type  <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (gnt[i]) pend_valid[i] <= 1'b0;
        if (raise[i] && !drop[i]) begin
          pend_valid[i] <= 1'b1;
          pend_type[i]  <= raise_type[i];
        end
      end
      if (gnt_any) rr_ptr <= (gnt_idx == BW'(NUM_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      if (|drop)             overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign push      = gnt_any;
  assign pop       = evt_valid & evt_ready;
  assign {evt_btn, evt_type} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {gnt_idx, pend_type[gnt_idx]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: timestamp-based event model, directed scenarios, random soak.
module tb_button_event_ctrl;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int LT = 3;
  localparam int RT = 2;
  localparam int FD = 4;
  localparam int PRESS = 0, RELEASE = 1, LONG = 2, REPEAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [1:0]    evt_btn;
  logic [1:0]    evt_type;
  logic          tick;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int checks = 0;
  int failures = 0;

  button_event_ctrl #(
    .NUM_BTN(NB), .TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_btn(evt_btn), .evt_type(evt_type), .tick(tick), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Model state: edge count, ticks consumed, per-button mode with tick timestamp anchors.
  int            m_k, m_tc, m_last;
  bit [NB-1:0]   m_b1, m_b2;
  int            m_mode [NB];
  int            m_anchor [NB];
  bit            m_pv [NB];
  int            m_pt [NB];
  bit            m_ovf;
  int            q_btn [$];
  int            q_type [$];
  int            lg [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lg_at(input int i);
    return (i < lg.size()) ? lg[i] : -1;
  endfunction

  task automatic model_reset();
    m_k = 0; m_tc = 0; m_last = NB - 1; m_b1 = '0; m_b2 = '0; m_ovf = 0;
    for (int i = 0; i < NB; i++) begin
      m_mode[i] = 0; m_anchor[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
    end
    q_btn.delete(); q_type.delete();
  endtask

  task automatic model_step(input logic [NB-1:0] btn, input logic rdy, input logic clr);
    bit tick_pre, rise, fall, drop, any_drop;
    int tc_post, gi, idx;
    bit ev [NB];
    int et [NB];
    tick_pre = (m_k > 0) && (m_k % TD == 0);
    tc_post  = m_tc + (tick_pre ? 1 : 0);
    for (int i = 0; i < NB; i++) begin
      ev[i] = 0; et[i] = 0;
      rise = m_b1[i] & ~m_b2[i];
      fall = ~m_b1[i] & m_b2[i];
      case (m_mode[i])
        0: if (rise) begin ev[i] = 1; et[i] = PRESS; m_mode[i] = 1; m_anchor[i] = tc_post; end
        1: begin
          if (fall) begin ev[i] = 1; et[i] = RELEASE; m_mode[i] = 0; end
          else if (m_tc - m_anchor[i] == LT) begin
            ev[i] = 1; et[i] = LONG; m_mode[i] = 2; m_anchor[i] = tc_post;
          end
        end
        default: begin
          if (fall) begin ev[i] = 1; et[i] = RELEASE; m_mode[i] = 0; end
`ifdef AUTO_REPEAT_EN
          else if (m_tc - m_anchor[i] == RT) begin ev[i] = 1; et[i] = REPEAT; m_anchor[i] = tc_post; end
`endif
        end
      endcase
    end
    gi = -1;
    if (q_btn.size() < FD)
      for (int k = 1; k <= NB; k++) begin
        idx = (m_last + k) % NB;
        if (gi < 0 && m_pv[idx]) gi = idx;
      end
    if (q_btn.size() > 0 && rdy) begin
      void'(q_btn.pop_front()); void'(q_type.pop_front());
    end
    if (gi >= 0) begin
      q_btn.push_back(gi); q_type.push_back(m_pt[gi]); m_last = gi;
    end
    any_drop = 0;
    for (int i = 0; i < NB; i++) begin
      drop = ev[i] && m_pv[i] && (i != gi);
      if (i == gi) m_pv[i] = 0;
      if (ev[i] && !drop) begin m_pv[i] = 1; m_pt[i] = et[i]; end
      if (drop) any_drop = 1;
    end
    if (any_drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_b2 = m_b1; m_b1 = btn; m_tc = tc_post; m_k++;
  endtask

  task automatic compare();
    chk("tick", tick, ((m_k > 0) && (m_k % TD == 0)) ? 1 : 0);
    chk("evt_valid", evt_valid, (q_btn.size() > 0) ? 1 : 0);
    chk("overflow", overflow, m_ovf);
    if (q_btn.size() > 0) begin
      chk("evt_btn", evt_btn, q_btn[0]);
      chk("evt_type", evt_type, q_type[0]);
    end
  endtask

  // Entered and left at a negative edge; inputs change here, outputs checked 1 after posedge.
  task automatic cycle(input logic [NB-1:0] b, input logic rdy, input logic clr);
    btn_in = b; evt_ready = rdy; clr_overflow = clr;
    if (evt_valid && rdy) lg.push_back(32'(evt_btn) * 4 + 32'(evt_type));
    @(posedge clk);
    model_step(b, rdy, clr);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_in = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_btn", evt_btn, 0);
    chk("rst_evt_type", evt_type, 0);
    chk("rst_tick", tick, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    lg.delete();
  endtask

  initial begin
    model_reset();

    // Short press on button 0: PRESS then RELEASE, no LONG.
    do_reset();
    cycle(4'b0001, 1, 0); cycle(4'b0001, 1, 0);
    chk("t1_not_yet_valid", evt_valid, 0);
    cycle(4'b0001, 1, 0);
    chk("t1_press_valid", evt_valid, 1);
    chk("t1_press_btn", evt_btn, 0);
    repeat (5) cycle(4'b0001, 1, 0);
    repeat (8) cycle(4'b0000, 1, 0);
    chk("t1_log_n", lg.size(), 2);
    chk("t1_log0", lg_at(0), 0 * 4 + PRESS);
    chk("t1_log1", lg_at(1), 0 * 4 + RELEASE);

    // Long hold on button 2.
    do_reset();
    repeat (40) cycle(4'b0100, 1, 0);
    repeat (8) cycle(4'b0000, 1, 0);
    chk("t2_log0", lg_at(0), 2 * 4 + PRESS);
    chk("t2_log1", lg_at(1), 2 * 4 + LONG);
    chk("t2_last", lg_at(lg.size() - 1), 2 * 4 + RELEASE);
`ifdef AUTO_REPEAT_EN
    chk("t2_has_repeat", lg_at(2), 2 * 4 + REPEAT);
`else
    chk("t2_log_n", lg.size(), 3);
`endif

    // All buttons at once: round-robin order from index 0.
    do_reset();
    repeat (8) cycle(4'b1111, 1, 0);
    repeat (8) cycle(4'b0000, 1, 0);
    repeat (8) cycle(4'b1111, 1, 0);
    repeat (6) cycle(4'b0000, 1, 0);
    for (int i = 0; i < NB; i++) chk("t3_rr_press", lg_at(i), i * 4 + PRESS);

    // Full FIFO: fifth event waits in its pending slot without loss.
    do_reset();
    cycle(4'b0001, 0, 0); cycle(4'b0011, 0, 0); cycle(4'b0111, 0, 0); cycle(4'b1111, 0, 0);
    cycle(4'b1111, 0, 0); cycle(4'b1111, 0, 0);
    cycle(4'b1110, 0, 0); cycle(4'b1110, 0, 0); cycle(4'b1110, 0, 0);
    chk("t4_valid_full", evt_valid, 1);
    chk("t4_no_overflow", overflow, 0);
    cycle(4'b1110, 1, 0);
    cycle(4'b1110, 0, 0);
    chk("t4_popped", lg_at(0), 0 * 4 + PRESS);
    chk("t4_head_btn", evt_btn, 1);
    chk("t4_head_type", evt_type, PRESS);
    chk("t4_no_overflow2", overflow, 0);

    // Overflow on a second event while the slot is still pending, then clear.
    do_reset();
    cycle(4'b0001, 0, 0); cycle(4'b0101, 0, 0); cycle(4'b1101, 0, 0); cycle(4'b1101, 0, 0);
    cycle(4'b1100, 0, 0); cycle(4'b1100, 0, 0); cycle(4'b1100, 0, 0);
    cycle(4'b1110, 0, 0); cycle(4'b1110, 0, 0); cycle(4'b1100, 0, 0); cycle(4'b1100, 0, 0);
    chk("t5_overflow_set", overflow, 1);
    cycle(4'b1100, 0, 1);
    chk("t5_overflow_clr", overflow, 0);

    // Asynchronous reset mid-stream with button 0 held.
    do_reset();
    repeat (6) cycle(4'b0111, 0, 0);
    chk("t6_valid_before", evt_valid, 1);
    btn_in = 4'b0001;
    #2 rst_n = 1'b0;
    #1 chk("t6_async_drop", evt_valid, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) cycle(4'b0001, 0, 0);
    chk("t6_repress_valid", evt_valid, 1);
    chk("t6_repress_btn", evt_btn, 0);
    chk("t6_repress_type", evt_type, PRESS);

    // Random soak.
    do_reset();
    begin
      logic [NB-1:0] b;
      logic rdy, clr;
      int stall;
      b = '0; stall = 0;
      for (int n = 0; n < 4000; n++) begin
        for (int i = 0; i < NB; i++) if ($urandom_range(0, 29) == 0) b[i] = ~b[i];
        if (stall > 0) stall--;
        else if ($urandom_range(0, 99) == 0) stall = $urandom_range(5, 40);
        rdy = (stall == 0) && ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 49) == 0);
        cycle(b, rdy, clr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
